// File: rtl/adaptive_loop_filter.sv
// Two-stage PI loop filter for a digital PLL with ACQ/TRK gain switching, lock detect and saturation.
// Latency: dco_cc_valid_o two edges after error_valid_i; no backpressure, one sample per cycle.
module adaptive_loop_filter #(
    parameter int ERROR_WIDTH   = 8,
    parameter int DCO_CC_WIDTH  = 9,
    parameter int FRAC_WIDTH    = 4,
    parameter int ACQ_KP_SHIFT  = 0,
    parameter int ACQ_KI_SHIFT  = 2,
    parameter int TRK_KP_SHIFT  = 1,
    parameter int TRK_KI_SHIFT  = 4,
    parameter int LOCK_THRESH   = 2,
    parameter int LOCK_COUNT    = 4,
    parameter int UNLOCK_THRESH = 8,
    parameter int UNLOCK_COUNT  = 2
) (
    input  logic                    gen_clk_i,
    input  logic                    reset_n_i,
    input  logic [ERROR_WIDTH-1:0]  error_i,
    input  logic                    error_valid_i,
    input  logic                    hold_i,
    input  logic                    force_acq_i,
    output logic [DCO_CC_WIDTH-1:0] dco_cc_o,
    output logic                    dco_cc_valid_o,
    output logic                    locked_o,
    output logic                    sat_o
);

    localparam int IW = DCO_CC_WIDTH + FRAC_WIDTH;
    // Internal sum width leaves headroom for integrator plus the largest proportional term.
    localparam int SW = IW + ERROR_WIDTH + FRAC_WIDTH + 2;
    localparam int CW = $clog2(LOCK_COUNT + UNLOCK_COUNT + 1);

    localparam logic signed [SW-1:0] I_MAX = (SW'(1) << (IW - 1)) - SW'(1);
    localparam logic signed [SW-1:0] I_MIN = -(SW'(1) << (IW - 1));
    localparam logic signed [SW-1:0] O_MAX = (SW'(1) << (DCO_CC_WIDTH - 1)) - SW'(1);
    localparam logic signed [SW-1:0] O_MIN = -(SW'(1) << (DCO_CC_WIDTH - 1));
    localparam logic [ERROR_WIDTH:0] LOCK_TH   = LOCK_THRESH[ERROR_WIDTH:0];
    localparam logic [ERROR_WIDTH:0] UNLOCK_TH = UNLOCK_THRESH[ERROR_WIDTH:0];
    localparam logic [CW-1:0]        LOCK_LAST   = CW'(LOCK_COUNT - 1);
    localparam logic [CW-1:0]        UNLOCK_LAST = CW'(UNLOCK_COUNT - 1);

    typedef enum logic {S_ACQ, S_TRK} state_t;

    state_t                   r_state;
    state_t                   w_state_n;
    logic [CW-1:0]            r_lock_cnt, w_lock_cnt_n;
    logic [CW-1:0]            r_unlock_cnt, w_unlock_cnt_n;

    logic signed [ERROR_WIDTH-1:0] r_err;
    logic                          r_err_vld;
    logic signed [IW-1:0]          r_int;
    logic [DCO_CC_WIDTH-1:0]       r_dco;
    logic                          r_dco_vld;
    logic                          r_sat;

    logic signed [SW-1:0]      w_s, w_kp, w_ki, w_i_ext, w_i_sum, w_i_new, w_o_sum, w_o_shr;
    logic [DCO_CC_WIDTH-1:0]   w_dco;
    logic                      w_sat;
    logic signed [ERROR_WIDTH:0] w_e_ext;
    logic [ERROR_WIDTH:0]      w_abs;

    always_comb begin
        w_s     = {{(SW - ERROR_WIDTH){r_err[ERROR_WIDTH-1]}}, r_err} << FRAC_WIDTH;
        w_kp    = (r_state == S_TRK) ? (w_s >>> TRK_KP_SHIFT) : (w_s >>> ACQ_KP_SHIFT);
        w_ki    = (r_state == S_TRK) ? (w_s >>> TRK_KI_SHIFT) : (w_s >>> ACQ_KI_SHIFT);
        w_i_ext = {{(SW - IW){r_int[IW-1]}}, r_int};
        w_i_sum = w_i_ext + w_ki;
        if (hold_i)
            w_i_new = w_i_ext;
        else if (w_i_sum > I_MAX)
            w_i_new = I_MAX;
        else if (w_i_sum < I_MIN)
            w_i_new = I_MIN;
        else
            w_i_new = w_i_sum;

        w_o_sum = w_i_new + w_kp;
        w_o_shr = w_o_sum >>> FRAC_WIDTH;
        w_sat   = 1'b1;
        if (w_o_shr > O_MAX)
            w_dco = O_MAX[DCO_CC_WIDTH-1:0];
        else if (w_o_shr < O_MIN)
            w_dco = O_MIN[DCO_CC_WIDTH-1:0];
        else begin
            w_dco = w_o_shr[DCO_CC_WIDTH-1:0];
            w_sat = 1'b0;
        end

        w_e_ext = {r_err[ERROR_WIDTH-1], r_err};
        if (w_e_ext[ERROR_WIDTH])
            w_abs = -w_e_ext;
        else
            w_abs = w_e_ext;
    end

    // Lock detector: only stage-2 valid samples advance or clear the counters.
    always_comb begin
        w_state_n      = r_state;
        w_lock_cnt_n   = r_lock_cnt;
        w_unlock_cnt_n = r_unlock_cnt;
        if (force_acq_i) begin
            w_state_n      = S_ACQ;
            w_lock_cnt_n   = '0;
            w_unlock_cnt_n = '0;
        end else if (r_err_vld) begin
            case (r_state)
                S_ACQ: begin
                    if (w_abs <= LOCK_TH) begin
                        if (r_lock_cnt == LOCK_LAST) begin
                            w_state_n    = S_TRK;
                            w_lock_cnt_n = '0;
                        end else begin
                            w_lock_cnt_n = r_lock_cnt + 1'b1;
                        end
                    end else begin
                        w_lock_cnt_n = '0;
                    end
                end
                S_TRK: begin
                    if (w_abs > UNLOCK_TH) begin
                        if (r_unlock_cnt == UNLOCK_LAST) begin
                            w_state_n      = S_ACQ;
                            w_unlock_cnt_n = '0;
                        end else begin
                            w_unlock_cnt_n = r_unlock_cnt + 1'b1;
                        end
                    end else begin
                        w_unlock_cnt_n = '0;
                    end
                end
                default: w_state_n = S_ACQ;
            endcase
        end
    end

    always_ff @(posedge gen_clk_i) begin
        if (!reset_n_i) begin
            r_state      <= S_ACQ;
            r_lock_cnt   <= '0;
            r_unlock_cnt <= '0;
        end else begin
            r_state      <= w_state_n;
            r_lock_cnt   <= w_lock_cnt_n;
            r_unlock_cnt <= w_unlock_cnt_n;
        end
    end

    always_ff @(posedge gen_clk_i) begin
        if (!reset_n_i) begin
            r_err     <= '0;
            r_err_vld <= 1'b0;
            r_int     <= '0;
            r_dco     <= '0;
            r_dco_vld <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            r_err     <= error_i;
            r_err_vld <= error_valid_i;
            r_dco_vld <= r_err_vld;
            if (r_err_vld) begin
                r_int <= w_i_new[IW-1:0];
                r_dco <= w_dco;
                r_sat <= w_sat;
            end
        end
    end

    assign dco_cc_o       = r_dco;
    assign dco_cc_valid_o = r_dco_vld;
    assign sat_o          = r_sat;
    assign locked_o       = (r_state == S_TRK);

endmodule
